// File: rtl/ariane_axi_pkg.sv
// Ariane AXI slave-side channel and bundle types, plus the pipeline-cut and
// isolation enums shared by the slave connector.
package ariane_axi;

    localparam int unsigned AddrWidth  = 64;
    localparam int unsigned DataWidth  = 64;
    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned IdWidthSlv = 4;
    localparam int unsigned UserWidth  = 1;

    typedef logic [IdWidthSlv-1:0] id_slv_t;
    typedef logic [AddrWidth-1:0]  addr_t;
    typedef logic [DataWidth-1:0]  data_t;
    typedef logic [StrbWidth-1:0]  strb_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        CUT_BYPASS = 2'd0,
        CUT_REG    = 2'd1,
        CUT_SPILL  = 2'd2
    } cut_mode_e;

    typedef enum logic [1:0] {
        ISO_NORMAL   = 2'd0,
        ISO_DRAIN    = 2'd1,
        ISO_ISOLATED = 2'd2
    } iso_state_e;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
    } aw_chan_slv_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_slv_t    id;
        logic [1:0] resp;
    } b_chan_slv_t;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
    } ar_chan_slv_t;

    typedef struct packed {
        id_slv_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
    } r_chan_slv_t;

    typedef struct packed {
        aw_chan_slv_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        ar_chan_slv_t ar;
        logic         ar_valid;
        logic         r_ready;
    } req_slv_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        b_chan_slv_t  b;
        logic         r_valid;
        r_chan_slv_t  r;
    } resp_slv_t;

endpackage

// File: rtl/axi_bus.sv
// Signal-level AXI4+ATOP bus interface used for SoC-level wiring.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = ariane_axi::AddrWidth,
    parameter int unsigned AXI_DATA_WIDTH = ariane_axi::DataWidth,
    parameter int unsigned AXI_ID_WIDTH   = ariane_axi::IdWidthSlv,
    parameter int unsigned AXI_USER_WIDTH = ariane_axi::UserWidth
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );

endinterface

// File: rtl/axi_slave_connect_cut_slot.sv
// One valid/ready pipeline cut, generic over payload type: bypass wires,
// a single half-throughput register, or a two-entry full-throughput spill register.
module axi_cut_slot
    import ariane_axi::*;
#(
    parameter type       T    = logic,
    parameter cut_mode_e Mode = CUT_SPILL
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (Mode == CUT_SPILL) begin : g_spill
        logic [1:0] cnt_q, cnt_d;
        logic       rd_q, wr_q;
        T           mem_q [2];
        logic       push, pop;

        assign ready_o = (cnt_q != 2'd2);
        assign valid_o = (cnt_q != 2'd0);
        assign data_o  = mem_q[rd_q];
        assign push    = valid_i && ready_o;
        assign pop     = valid_o && ready_i;

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + 2'd1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 2'd1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= 2'd0;
                rd_q  <= 1'b0;
                wr_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                rd_q  <= rd_q ^ pop;
                wr_q  <= wr_q ^ push;
            end
        end

        // Payload storage carries no reset; occupancy alone decides validity.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end else if (Mode == CUT_REG) begin : g_reg
        logic full_q;
        T     data_q;

        assign ready_o = !full_q;
        assign valid_o = full_q;
        assign data_o  = data_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                full_q <= 1'b0;
            end else if (!full_q) begin
                full_q <= valid_i;
            end else if (ready_i) begin
                full_q <= 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!full_q && valid_i) begin
                data_q <= data_i;
            end
        end
    end else begin : g_bypass
        logic unused_clk_rst;

        assign unused_clk_rst = clk_i ^ rst_i;
        assign ready_o        = ready_i;
        assign valid_o        = valid_i;
        assign data_o         = data_i;
    end

endmodule

// File: rtl/axi_slave_connect_cut.sv
// AXI_BUS slave to ariane_axi struct bridge with per-channel pipeline cuts,
// outstanding-transaction caps and a drain-and-isolate handshake.
module axi_slave_connect_cut
    import ariane_axi::*;
#(
    parameter int unsigned AwCut    = 2,
    parameter int unsigned WCut     = 2,
    parameter int unsigned BCut     = 2,
    parameter int unsigned ArCut    = 2,
    parameter int unsigned RCut     = 2,
    parameter int unsigned MaxWTxns = 8,
    parameter int unsigned MaxRTxns = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          isolate_i,
    output logic                          isolated_o,
    output logic [$clog2(MaxWTxns+1)-1:0] w_outstanding_o,
    output logic [$clog2(MaxRTxns+1)-1:0] r_outstanding_o,
    output req_slv_t                      axi_req_o,
    input  resp_slv_t                     axi_resp_i,
    AXI_BUS.Slave                         slave
);

    localparam int unsigned WCntW = $clog2(MaxWTxns + 1);
    localparam int unsigned RCntW = $clog2(MaxRTxns + 1);
    localparam logic [WCntW-1:0] WCntMax = WCntW'(MaxWTxns);
    localparam logic [RCntW-1:0] RCntMax = RCntW'(MaxRTxns);
    localparam cut_mode_e AwMode = cut_mode_e'(AwCut);
    localparam cut_mode_e WMode  = cut_mode_e'(WCut);
    localparam cut_mode_e BMode  = cut_mode_e'(BCut);
    localparam cut_mode_e ArMode = cut_mode_e'(ArCut);
    localparam cut_mode_e RMode  = cut_mode_e'(RCut);

    iso_state_e       state_q;
    logic             isolated_q;
    logic [WCntW-1:0] w_cnt_q, w_cnt_d;
    logic [RCntW-1:0] r_cnt_q, r_cnt_d;

    aw_chan_slv_t aw_in, aw_out;
    w_chan_t      w_in, w_out;
    b_chan_slv_t  b_out;
    ar_chan_slv_t ar_in, ar_out;
    r_chan_slv_t  r_out;

    logic aw_in_valid, aw_in_ready, aw_out_valid;
    logic w_in_ready, w_out_valid;
    logic b_in_ready, b_out_valid;
    logic ar_in_valid, ar_in_ready, ar_out_valid;
    logic r_in_ready, r_out_valid;
    logic aw_open, ar_open;
    logic aw_hs, b_hs, ar_hs, r_last_hs;
    logic slices_empty, drained;
    logic unused_user;

    // User sideband has no field in the struct bundle.
    assign unused_user = ^{slave.aw_user, slave.ar_user, slave.w_user};

    always_comb begin
        aw_in        = '0;
        aw_in.id     = slave.aw_id;
        aw_in.addr   = slave.aw_addr;
        aw_in.len    = slave.aw_len;
        aw_in.size   = slave.aw_size;
        aw_in.burst  = slave.aw_burst;
        aw_in.lock   = slave.aw_lock;
        aw_in.cache  = slave.aw_cache;
        aw_in.prot   = slave.aw_prot;
        aw_in.qos    = slave.aw_qos;
        aw_in.region = slave.aw_region;
        aw_in.atop   = slave.aw_atop;
        w_in         = '0;
        w_in.data    = slave.w_data;
        w_in.strb    = slave.w_strb;
        w_in.last    = slave.w_last;
        ar_in        = '0;
        ar_in.id     = slave.ar_id;
        ar_in.addr   = slave.ar_addr;
        ar_in.len    = slave.ar_len;
        ar_in.size   = slave.ar_size;
        ar_in.burst  = slave.ar_burst;
        ar_in.lock   = slave.ar_lock;
        ar_in.cache  = slave.ar_cache;
        ar_in.prot   = slave.ar_prot;
        ar_in.qos    = slave.ar_qos;
        ar_in.region = slave.ar_region;
    end

    // Address channels close while draining/isolated or when the cap is reached.
    assign aw_open = (state_q == ISO_NORMAL) && (w_cnt_q != WCntMax);
    assign ar_open = (state_q == ISO_NORMAL) && (r_cnt_q != RCntMax);

    assign aw_in_valid    = slave.aw_valid && aw_open;
    assign ar_in_valid    = slave.ar_valid && ar_open;
    assign slave.aw_ready = aw_in_ready && aw_open;
    assign slave.ar_ready = ar_in_ready && ar_open;
    assign slave.w_ready  = w_in_ready;

    assign slave.b_id    = b_out.id;
    assign slave.b_resp  = b_out.resp;
    assign slave.b_user  = '0;
    assign slave.b_valid = b_out_valid;
    assign slave.r_id    = r_out.id;
    assign slave.r_data  = r_out.data;
    assign slave.r_resp  = r_out.resp;
    assign slave.r_last  = r_out.last;
    assign slave.r_user  = '0;
    assign slave.r_valid = r_out_valid;

    axi_cut_slot #(.T(aw_chan_slv_t), .Mode(AwMode)) u_aw_cut (
        .clk_i, .rst_i,
        .valid_i(aw_in_valid),  .ready_o(aw_in_ready), .data_i(aw_in),
        .valid_o(aw_out_valid), .ready_i(axi_resp_i.aw_ready), .data_o(aw_out)
    );

    axi_cut_slot #(.T(w_chan_t), .Mode(WMode)) u_w_cut (
        .clk_i, .rst_i,
        .valid_i(slave.w_valid), .ready_o(w_in_ready), .data_i(w_in),
        .valid_o(w_out_valid),   .ready_i(axi_resp_i.w_ready), .data_o(w_out)
    );

    axi_cut_slot #(.T(b_chan_slv_t), .Mode(BMode)) u_b_cut (
        .clk_i, .rst_i,
        .valid_i(axi_resp_i.b_valid), .ready_o(b_in_ready), .data_i(axi_resp_i.b),
        .valid_o(b_out_valid),        .ready_i(slave.b_ready), .data_o(b_out)
    );

    axi_cut_slot #(.T(ar_chan_slv_t), .Mode(ArMode)) u_ar_cut (
        .clk_i, .rst_i,
        .valid_i(ar_in_valid),  .ready_o(ar_in_ready), .data_i(ar_in),
        .valid_o(ar_out_valid), .ready_i(axi_resp_i.ar_ready), .data_o(ar_out)
    );

    axi_cut_slot #(.T(r_chan_slv_t), .Mode(RMode)) u_r_cut (
        .clk_i, .rst_i,
        .valid_i(axi_resp_i.r_valid), .ready_o(r_in_ready), .data_i(axi_resp_i.r),
        .valid_o(r_out_valid),        .ready_i(slave.r_ready), .data_o(r_out)
    );

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw       = aw_out;
        axi_req_o.aw_valid = aw_out_valid;
        axi_req_o.w        = w_out;
        axi_req_o.w_valid  = w_out_valid;
        axi_req_o.b_ready  = b_in_ready;
        axi_req_o.ar       = ar_out;
        axi_req_o.ar_valid = ar_out_valid;
        axi_req_o.r_ready  = r_in_ready;
    end

    assign aw_hs     = slave.aw_valid && slave.aw_ready;
    assign b_hs      = b_out_valid && slave.b_ready;
    assign ar_hs     = slave.ar_valid && slave.ar_ready;
    assign r_last_hs = r_out_valid && slave.r_ready && r_out.last;

    // A response with nothing outstanding is a protocol error; the count floors at zero.
    always_comb begin
        w_cnt_d = w_cnt_q;
        if (aw_hs && !b_hs) begin
            w_cnt_d = w_cnt_q + WCntW'(1);
        end else if (b_hs && !aw_hs && (w_cnt_q != '0)) begin
            w_cnt_d = w_cnt_q - WCntW'(1);
        end
        r_cnt_d = r_cnt_q;
        if (ar_hs && !r_last_hs) begin
            r_cnt_d = r_cnt_q + RCntW'(1);
        end else if (r_last_hs && !ar_hs && (r_cnt_q != '0)) begin
            r_cnt_d = r_cnt_q - RCntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_cnt_q <= '0;
            r_cnt_q <= '0;
        end else begin
            w_cnt_q <= w_cnt_d;
            r_cnt_q <= r_cnt_d;
        end
    end

    a_no_b_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_hs && !aw_hs && (w_cnt_q == '0)));
    a_no_r_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_last_hs && !ar_hs && (r_cnt_q == '0)));

    // A bypass slice holds nothing, so it never blocks draining.
    assign slices_empty = ((AwMode == CUT_BYPASS) || !aw_out_valid)
                       && ((WMode  == CUT_BYPASS) || !w_out_valid)
                       && ((BMode  == CUT_BYPASS) || !b_out_valid)
                       && ((ArMode == CUT_BYPASS) || !ar_out_valid)
                       && ((RMode  == CUT_BYPASS) || !r_out_valid);
    assign drained = slices_empty && (w_cnt_q == '0) && (r_cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ISO_NORMAL;
            isolated_q <= 1'b0;
        end else begin
            case (state_q)
                ISO_NORMAL: begin
                    if (isolate_i) begin
                        state_q <= ISO_DRAIN;
                    end
                end
                ISO_DRAIN: begin
                    if (!isolate_i) begin
                        state_q <= ISO_NORMAL;
                    end else if (drained) begin
                        state_q    <= ISO_ISOLATED;
                        isolated_q <= 1'b1;
                    end
                end
                ISO_ISOLATED: begin
                    if (!isolate_i) begin
                        state_q    <= ISO_NORMAL;
                        isolated_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ISO_NORMAL;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

    assign isolated_o      = isolated_q;
    assign w_outstanding_o = w_cnt_q;
    assign r_outstanding_o = r_cnt_q;

endmodule

// File: doc/axi_slave_connect_cut.md
Name: axi_slave_connect_cut

Overview:
- Converts an `AXI_BUS.Slave` interface into the `ariane_axi` slave request/response structs.
- Each of the five channels gets an independently parametrised pipeline cut: bypass, single register, or full-throughput spill register.
- Tracks outstanding write and read transactions on the upstream side and caps them.
- Provides a drain-and-isolate handshake, so the downstream slave can be safely quiesced (e.g. for clock gating or reset).
- Sits between SoC-level interface wiring and struct-based Ariane peripherals.

Parameters:
- AwCut, 2, AW slice mode: 0 bypass (combinational), 1 single register (1-cycle latency, half throughput), 2 spill register (1-cycle latency, full throughput).
- WCut, 2, W slice mode, encoding as AwCut.
- BCut, 2, B slice mode, encoding as AwCut.
- ArCut, 2, AR slice mode, encoding as AwCut.
- RCut, 2, R slice mode, encoding as AwCut.
- MaxWTxns, 8, maximum outstanding writes (AW accepted, B not yet returned); must be ≥1.
- MaxRTxns, 8, maximum outstanding reads (AR accepted, last R not yet returned); must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- isolate_i  in  1  request to drain and isolate the downstream slave.
- isolated_o  out  1  high while isolated: no outstanding transactions, all slices empty.
- w_outstanding_o  out  $clog2(MaxWTxns+1)  current write count.
- r_outstanding_o  out  $clog2(MaxRTxns+1)  current read count.
- axi_req_o  out  ariane_axi::req_slv_t  downstream request.
- axi_resp_i  in  ariane_axi::resp_slv_t  downstream response.
- slave  modport  AXI_BUS.Slave  upstream interface.

Behaviour:
- Field mapping:
  - AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region map one-to-one.
  - aw.atop maps through; aw_user/ar_user/w_user are dropped.
  - slave.b_user and slave.r_user are driven 0.
- Slice rules:
  - Every slice obeys valid/ready: payload is held stable while valid && !ready.
  - Mode 2 spill register: two entries, accepts one beat per cycle when downstream is ready, upstream ready = !full.
  - Mode 1 single register: ready = empty.
  - Mode 0: pure wires.
- Reset (rst_i high, any cycle):
  - All slices empty; all downstream valids and upstream b_valid/r_valid are 0.
  - Counters are 0; FSM goes to NORMAL; isolated_o = 0.
  - Mid-transaction reset discards in-flight beats without error.
- Counters (upstream handshakes):
  - Write count: +1 on slave AW handshake, −1 on slave B handshake; both in one cycle leaves it unchanged.
  - Read count: +1 on AR handshake, −1 on R handshake with r_last; simultaneous events leave it unchanged.
  - Saturation: when write count == MaxWTxns, slave.aw_ready = 0 and the AW slice input valid = 0. AR is gated the same way with MaxRTxns.
  - Counters never wrap. A B or last-R handshake while the count is 0 is a protocol violation; assert in simulation and hold the count at 0.
- FSM states: NORMAL, DRAIN, ISOLATED.
  - NORMAL → DRAIN when isolate_i = 1.
  - DRAIN → ISOLATED when both counts == 0, all five slices are empty, and isolate_i = 1.
  - DRAIN → NORMAL when isolate_i = 0.
  - ISOLATED → NORMAL when isolate_i = 0.
  - In DRAIN and ISOLATED: slave.aw_ready = slave.ar_ready = 0, and AW/AR slice inputs are gated. W, B and R remain live so accepted bursts complete.
  - isolated_o is registered: it rises the cycle after the DRAIN → ISOLATED condition holds, and falls the cycle after isolate_i drops.
  - If isolate_i rises in the same cycle as an AW handshake, that AW is accepted and counted; gating begins the next cycle.
- Latency: the end-to-end latency of each channel equals its slice latency (0 or 1 cycle). The FSM adds none.

Decomposition:
- Package ariane_axi (existing):
  - req_slv_t and resp_slv_t.
  - Channel typedefs: aw_chan_slv_t, w_chan_t, b_chan_slv_t, ar_chan_slv_t, r_chan_slv_t.
- Add a cut-mode enum to the same package: CUT_BYPASS = 0, CUT_REG = 1, CUT_SPILL = 2.
- One sub-module, axi_cut_slot:
  - Generic over payload type (type parameter) and Mode.
  - Ports: clk_i, rst_i, valid_i/ready_o/data_i, valid_o/ready_i/data_o.
  - Instantiated five times.

Test Plan:
- Field mapping, default params: one AW with id=3, addr=0x8000_0040, len=3, one W burst of 4 beats, one B. AW appears downstream 1 cycle after the upstream handshake with identical fields; B returns id=3, resp=OKAY, b_user=0; write count goes 0→1→0.
- Throughput: mode 2 on R with 16 back-to-back beats and ready held high gives 16 beats in 16 consecutive cycles. Mode 1 takes 32 cycles. Mode 0 gives each beat in the same cycle.
- Saturation: MaxRTxns=2; issue 3 ARs with no R returned. The third AR sees ar_ready = 0 until the first last-R handshake; r_outstanding_o never exceeds 2.
- Backpressure: downstream w_ready toggles pseudo-randomly over 100 beats. No beat is lost or duplicated, and data/strb are stable while valid && !ready.
- Isolation: with 2 writes outstanding, raise isolate_i. aw_ready drops the next cycle; isolated_o rises 1 cycle after the second B and after the slices drain. Lower isolate_i: isolated_o falls the next cycle and a new AW is accepted.
- Reset: assert rst_i asynchronously mid-burst with w_outstanding=1 and the R slice full. All valids go 0 immediately, counters read 0, and isolated_o = 0.
